// File: rtl/mult_seq_pkg.sv
// Shared constants and types for the sequential shift-add multiplier.
package mult_seq_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER);
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } product_t;

endpackage

// File: rtl/mult_seq_if.sv
// Issue/result bus between the instruction pipeline and the multiplier.
interface mult_seq_if;
  import mult_seq_pkg::*;

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             rd_hilo;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_a, op_b, rd_hilo,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, op_a, op_b, rd_hilo,
    output stall, busy, done, hi, lo
  );

endinterface

// File: rtl/mult_datapath.sv
// Shift-add accumulator: 64-bit {partial product, multiplier} register and
// a 33-bit adder; one multiplier bit is retired per step.
module mult_datapath
  import mult_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [ACC_W-1:0] product_c
);

  logic [WIDTH-1:0] mcand;
  logic [ACC_W-1:0] acc;
  logic [WIDTH:0]   sum_c;

  // Carry out of the upper-half add becomes the new bit 63 after the shift.
  always_comb begin
    sum_c = {1'b0, acc[ACC_W-1:WIDTH]};
    if (acc[0]) begin
      sum_c = sum_c + {1'b0, mcand};
    end
    product_c = {sum_c, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= op_a;
      acc   <= {WIDTH'(0), op_b};
    end else if (step) begin
      acc   <= product_c;
    end
  end

endmodule

// File: rtl/mult_seq.sv
// Sequential 32x32 unsigned multiplier: control FSM, step counter,
// pipeline stall generation and the architectural HI/LO registers.
module mult_seq
  import mult_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mult_seq_if.slave  bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  product_t         res;
  logic             busy_c;
  logic             accept_c;
  logic             last_c;
  logic [ACC_W-1:0] product_c;

  assign busy_c   = (state == BUSY);
  assign accept_c = bus.start && !busy_c;
  assign last_c   = busy_c && (cnt == CNT_W'(ITER - 1));

  mult_datapath u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (accept_c),
    .step      (busy_c),
    .op_a      (bus.op_a),
    .op_b      (bus.op_b),
    .product_c (product_c)
  );

  // HI/LO only move on the final step, so an aborted run leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state <= BUSY;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (last_c) begin
            state <= DONE;
            res   <= product_t'(product_c);
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall must reach the PC in the same cycle the dependent instruction issues.
  assign bus.stall = busy_c && (bus.start || bus.rd_hilo);
  assign bus.busy  = busy_c;
  assign bus.done  = (state == DONE);
  assign bus.hi    = res.hi;
  assign bus.lo    = res.lo;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: a cycle-level reference model pushes exact
// products on acceptance, a monitor pops and compares on every done pulse.
module tb_mult_seq;
  import mult_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mult_seq_if bus ();

  mult_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_fail    = 0;
  logic [63:0] exp_q[$];
  int          remaining = 0;
  bit          exp_done  = 1'b0;
  logic [63:0] last_prod = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a multiply occupies the unit for ITER cycles after
  // acceptance; a request is only taken when the unit is not mid-run.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining = 0;
      exp_done  = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (remaining > 0) begin
        remaining--;
        exp_done = (remaining == 0);
      end else if (bus.start) begin
        remaining = int'(ITER);
        exp_q.push_back(64'(bus.op_a) * 64'(bus.op_b));
      end
    end
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_prod = '0;
      chk("rst_busy",  64'(bus.busy),  64'(0));
      chk("rst_done",  64'(bus.done),  64'(0));
      chk("rst_stall", 64'(bus.stall), 64'(0));
      chk("rst_hilo",  {bus.hi, bus.lo}, 64'(0));
    end else begin
      chk("busy",  64'(bus.busy),  64'(remaining > 0));
      chk("done",  64'(bus.done),  64'(exp_done));
      chk("stall", 64'(bus.stall), 64'((remaining > 0) && (bus.start || bus.rd_hilo)));
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL result_unexpected: done with empty queue, got 0x%0h at %0t",
                   {bus.hi, bus.lo}, $time);
        end else begin
          last_prod = exp_q.pop_front();
          chk("result", {bus.hi, bus.lo}, last_prod);
        end
      end else begin
        chk("hilo_hold", {bus.hi, bus.lo}, last_prod);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    cyc(1);
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.rd_hilo = 1'b0;
    bus.op_a    = '0;
    bus.op_b    = '0;
    #1 rst = 1'b1;
    cyc(2);
    bus.start   = 1'b1;
    bus.rd_hilo = 1'b1;
    #1;
    chk("rst_init_stall", 64'(bus.stall), 64'(0));
    chk("rst_init_hi",    64'(bus.hi),    64'(0));
    chk("rst_init_lo",    64'(bus.lo),    64'(0));
    bus.start   = 1'b0;
    bus.rd_hilo = 1'b0;
    rst = 1'b0;

    // Start immediately after reset release.
    issue(32'd3, 32'd5);
    cyc(34);
    chk("dir_3x5", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc(34);
    chk("dir_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    // Start held through BUSY with changing operands; taken again in DONE.
    bus.start = 1'b1;
    bus.op_a  = 32'h8000_0000;
    bus.op_b  = 32'd2;
    cyc(1);
    bus.op_a  = 32'h0;
    bus.op_b  = 32'h1234_5678;
    cyc(33);
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    cyc(34);
    chk("dir_b2b_second", {bus.hi, bus.lo}, 64'h0);

    // MFHI/MFLO issued mid-run and held past DONE.
    issue($urandom, $urandom);
    cyc(10);
    bus.rd_hilo = 1'b1;
    cyc(25);
    bus.rd_hilo = 1'b0;
    cyc(3);

    // Illegal decode in IDLE: start wins, no stall.
    bus.rd_hilo = 1'b1;
    issue(32'd6, 32'd7);
    bus.rd_hilo = 1'b0;
    cyc(34);
    chk("dir_6x7", {bus.hi, bus.lo}, 64'd42);

    // Reset in the middle of a run.
    issue(32'd3, 32'd5);
    cyc(34);
    issue(32'd7, 32'd9);
    cyc(11);
    rst = 1'b1;
    #1;
    chk("rst_mid_hi",   64'(bus.hi),   64'(0));
    chk("rst_mid_lo",   64'(bus.lo),   64'(0));
    chk("rst_mid_busy", 64'(bus.busy), 64'(0));
    cyc(1);
    rst = 1'b0;
    issue(32'd2, 32'd2);
    cyc(34);
    chk("dir_2x2", {bus.hi, bus.lo}, 64'd4);

    // Random traffic: starts while busy must be ignored and stalled.
    repeat (1200) begin
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.rd_hilo = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0:       bus.op_a = 32'hFFFF_FFFF;
        1:       bus.op_a = 32'h0;
        default: bus.op_a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       bus.op_b = 32'hFFFF_FFFF;
        1:       bus.op_b = 32'h1;
        default: bus.op_b = $urandom;
      endcase
      cyc(1);
    end
    bus.start   = 1'b0;
    bus.rd_hilo = 1'b0;
    cyc(40);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
